// File: rtl/spin_readout_accumulator.sv
// Per-spin readout accumulator: sums each spin's signed samples over a programmable
// number of round trips (saturating), then drains one word per spin over AXI-Stream.
module spin_readout_accumulator #(
    parameter int NUM_SPINS = 64,
    parameter int ACC_W     = 16,
    parameter int BASE_ADDR = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_in,
    input  logic [7:0]  val_in,
    input  logic        val_valid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        overflow,
    output logic        dropped
);

    localparam int IDX_W = (NUM_SPINS > 1) ? $clog2(NUM_SPINS) : 1;
    localparam logic [15:0] ADDR_SPINS  = 16'(BASE_ADDR);
    localparam logic [15:0] ADDR_ROUNDS = 16'(BASE_ADDR + 1);
    localparam logic [15:0] ADDR_CTRL   = 16'(BASE_ADDR + 2);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t      state, state_next;
    logic [24:0] gpio_q;
    logic        w_prev;
    logic        wr, arm, abort;
    logic [7:0]  cfg_spins, cfg_rounds;
    logic [7:0]  eff_spins_m1, eff_rounds_m1;
    logic [7:0]  sh_spins_m1, sh_rounds_m1;
    logic [7:0]  idx, round;
    logic        take, last_slot, last_round, hs, sat, sat_hit;

    logic signed [ACC_W-1:0] acc [NUM_SPINS];
    logic [ACC_W-1:0] acc_rd, val_ext, acc_wdata, sat_val;
    logic [ACC_W:0]   sum;
    logic [15:0]      acc16;

    logic unused_gpio_bits;
    assign unused_gpio_bits = &{1'b0, gpio_in[31:25]};

    // The config bus is sampled once; a write fires on the registered 0->1 edge of w_clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= '0;
            w_prev <= 1'b0;
        end else begin
            gpio_q <= gpio_in[24:0];
            w_prev <= gpio_q[24];
        end
    end

    assign wr    = gpio_q[24] & ~w_prev;
    assign arm   = wr && (gpio_q[15:0] == ADDR_CTRL) && gpio_q[16];
    assign abort = wr && (gpio_q[15:0] == ADDR_CTRL) && gpio_q[17];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_spins  <= '0;
            cfg_rounds <= '0;
        end else if (wr) begin
            if (gpio_q[15:0] == ADDR_SPINS)  cfg_spins  <= gpio_q[23:16];
            if (gpio_q[15:0] == ADDR_ROUNDS) cfg_rounds <= gpio_q[23:16];
        end
    end

    always_comb begin
        eff_spins_m1  = cfg_spins - 8'd1;
        eff_rounds_m1 = cfg_rounds - 8'd1;
        if (cfg_spins == 8'd0 || 9'(cfg_spins) > 9'(NUM_SPINS))
            eff_spins_m1 = 8'(NUM_SPINS - 1);
        if (cfg_rounds == 8'd0)
            eff_rounds_m1 = 8'd0;
    end

    // Saturating read-modify-write of the current slot, all in one cycle.
    assign acc_rd     = acc[idx[IDX_W-1:0]];
    assign val_ext    = {{(ACC_W-8){val_in[7]}}, val_in};
    assign sum        = {acc_rd[ACC_W-1], acc_rd} + {val_ext[ACC_W-1], val_ext};
    assign sat        = sum[ACC_W] != sum[ACC_W-1];
    assign sat_val    = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign acc_wdata  = (round == 8'd0) ? val_ext : (sat ? sat_val : sum[ACC_W-1:0]);

    assign take       = (state == ACCUM) && val_valid && !abort;
    assign sat_hit    = take && (round != 8'd0) && sat;
    assign last_slot  = idx == sh_spins_m1;
    assign last_round = round == sh_rounds_m1;

    // AXI-Stream: a word transfers on a cycle with tvalid && tready; while tvalid is
    // high and tready low, tdata/tlast hold because idx and the array are frozen in DRAIN.
    assign hs = (state == DRAIN) && m_axis_tready;

    generate
        if (ACC_W >= 16) begin : g_trunc
            assign acc16 = acc_rd[15:0];
        end else begin : g_sext
            assign acc16 = {{(16-ACC_W){acc_rd[ACC_W-1]}}, acc_rd};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (take) acc[idx[IDX_W-1:0]] <= acc_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (arm) state_next = ACCUM;
                ACCUM:   if (take && last_slot && last_round) state_next = DRAIN;
                DRAIN:   if (hs && last_slot) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        m_axis_tvalid = (state == DRAIN);
        m_axis_tlast  = (state == DRAIN) && last_slot;
        m_axis_tdata  = (state == DRAIN) ? {idx, 8'h00, acc16} : 32'h0;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            round        <= '0;
            overflow     <= 1'b0;
            dropped      <= 1'b0;
            sh_spins_m1  <= '0;
            sh_rounds_m1 <= '0;
        end else begin
            if (sat_hit) overflow <= 1'b1;
            if (val_valid && state != ACCUM) dropped <= 1'b1;
            if (abort) begin
                idx   <= '0;
                round <= '0;
            end else begin
                case (state)
                    IDLE: if (arm) begin
                        idx          <= '0;
                        round        <= '0;
                        overflow     <= 1'b0;
                        dropped      <= 1'b0;
                        sh_spins_m1  <= eff_spins_m1;
                        sh_rounds_m1 <= eff_rounds_m1;
                    end
                    ACCUM: if (take) begin
                        if (last_slot) begin
                            idx   <= '0;
                            round <= last_round ? 8'd0 : round + 8'd1;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                    DRAIN: if (hs) idx <= last_slot ? 8'd0 : idx + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spin_readout_accumulator.sv
// Directed bench: a 16-bit and a 9-bit accumulator share stimulus; drained words are
// scored against hand-computed expected queues.
module tb_spin_readout_accumulator;

    localparam int NS = 8;
    localparam logic [15:0] BASE = 16'd512;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [7:0]  val_in;
    logic        val_valid;
    logic        tready;
    logic [31:0] tdata_a, tdata_b;
    logic        tvalid_a, tvalid_b, tlast_a, tlast_b;
    logic        busy_a, busy_b, ovf_a, ovf_b, drop_a, drop_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int sample_q[$];

    spin_readout_accumulator #(.NUM_SPINS(NS), .ACC_W(16), .BASE_ADDR(512)) dut_a (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .val_in(val_in), .val_valid(val_valid),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready),
        .m_axis_tlast(tlast_a), .busy(busy_a), .overflow(ovf_a), .dropped(drop_a)
    );

    spin_readout_accumulator #(.NUM_SPINS(NS), .ACC_W(9), .BASE_ADDR(512)) dut_b (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .val_in(val_in), .val_valid(val_valid),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready),
        .m_axis_tlast(tlast_b), .busy(busy_b), .overflow(ovf_b), .dropped(drop_b)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] addr, input logic [7:0] data);
        gpio_in = {8'h00, data, addr};
        step();
        gpio_in[24] = 1'b1;
        step();
        step();
        gpio_in[24] = 1'b0;
        step();
        step();
    endtask

    task automatic send_all();
        while (sample_q.size() > 0) begin
            val_in    = 8'(sample_q.pop_front());
            val_valid = 1'b1;
            step();
        end
        val_valid = 1'b0;
    endtask

    function automatic logic [31:0] word(input int idx, input int v);
        logic [31:0] iv;
        logic [31:0] vv;
        iv = idx;
        vv = v;
        return {iv[7:0], 8'h00, vv[15:0]};
    endfunction

    task automatic push_both(input int idx, input int v);
        exp_a.push_back(word(idx, v));
        exp_b.push_back(word(idx, v));
    endtask

    task automatic drain(input int n, input int stall_word, input int stall_len,
                         input bit rnd, input bit inject);
        int got = 0;
        int stall_cnt = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_td = '0;
        logic prev_tl = 1'b0;
        logic [31:0] ea, eb;
        while (got < n && cyc < 400) begin
            if (prev_stall) begin
                check_eq("hold_tdata", tdata_a, prev_td);
                check_eq("hold_tlast", 32'(tlast_a), 32'(prev_tl));
            end
            if (got == stall_word && stall_cnt < stall_len) begin
                tready = 1'b0;
                stall_cnt++;
            end else if (rnd) begin
                tready = 1'($urandom_range(0, 1));
            end else begin
                tready = 1'b1;
            end
            val_valid = inject && (cyc == 1);
            if (tvalid_a && tready) begin
                ea = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hDEAD_BEEF;
                eb = (exp_b.size() > 0) ? exp_b.pop_front() : 32'hDEAD_BEEF;
                check_eq("tdata_a", tdata_a, ea);
                check_eq("tdata_b", tdata_b, eb);
                check_eq("tlast_a", 32'(tlast_a), 32'(got == n - 1));
                check_eq("tlast_b", 32'(tlast_b), 32'(got == n - 1));
                got++;
            end
            prev_stall = tvalid_a && !tready;
            prev_td    = tdata_a;
            prev_tl    = tlast_a;
            step();
            cyc++;
        end
        val_valid = 1'b0;
        tready    = 1'b1;
        check_eq("drain_count", got, n);
        check_eq("tvalid_after", 32'(tvalid_a), 32'd0);
        check_eq("busy_a_after", 32'(busy_a), 32'd0);
        check_eq("busy_b_after", 32'(busy_b), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        gpio_in   = '0;
        val_in    = '0;
        val_valid = 1'b0;
        tready    = 1'b1;
        step();
        step();
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_tvalid", 32'(tvalid_a), 32'd0);
        check_eq("rst_tdata", tdata_a, 32'd0);
        check_eq("rst_tlast", 32'(tlast_a), 32'd0);
        check_eq("rst_overflow", 32'(ovf_a), 32'd0);
        check_eq("rst_dropped", 32'(drop_a), 32'd0);
        rst = 1'b0;
        step();

        // Basic accumulate: 4 spins x 2 rounds.
        cfg_write(BASE, 8'd4);
        cfg_write(BASE + 16'd1, 8'd2);
        cfg_write(BASE + 16'd2, 8'd1);
        check_eq("armed_busy", 32'(busy_a), 32'd1);
        sample_q = {1, 2, 3, 4, 10, -20, 30, -40};
        send_all();
        check_eq("drain_tvalid", 32'(tvalid_a), 32'd1);
        push_both(0, 11); push_both(1, -18); push_both(2, 33); push_both(3, -36);
        drain(4, -1, 0, 1'b0, 1'b0);
        check_eq("basic_ovf_a", 32'(ovf_a), 32'd0);
        check_eq("basic_ovf_b", 32'(ovf_b), 32'd0);
        check_eq("basic_dropped", 32'(drop_a), 32'd0);

        // Samples in IDLE are dropped.
        val_in = 8'd100; val_valid = 1'b1; step(); val_valid = 1'b0;
        check_eq("idle_dropped", 32'(drop_a), 32'd1);
        check_eq("idle_busy", 32'(busy_a), 32'd0);

        // Second run overwrites stale data; backpressure plus a sample during DRAIN.
        cfg_write(BASE + 16'd2, 8'd1);
        check_eq("arm_clears_dropped", 32'(drop_a), 32'd0);
        sample_q = {5, 6, 7, 8, 1, 1, 1, 1};
        send_all();
        push_both(0, 6); push_both(1, 7); push_both(2, 8); push_both(3, 9);
        drain(4, 1, 5, 1'b1, 1'b1);
        check_eq("drain_dropped", 32'(drop_a), 32'd1);

        // Saturation: 2 spins x 4 rounds of +127, then of -128.
        cfg_write(BASE, 8'd2);
        cfg_write(BASE + 16'd1, 8'd4);
        cfg_write(BASE + 16'd2, 8'd1);
        sample_q = {127, 127, 127, 127, 127, 127, 127, 127};
        send_all();
        exp_a.push_back(word(0, 508)); exp_a.push_back(word(1, 508));
        exp_b.push_back(32'h0000_00FF); exp_b.push_back(32'h0100_00FF);
        drain(2, -1, 0, 1'b0, 1'b0);
        check_eq("sat_pos_ovf_a", 32'(ovf_a), 32'd0);
        check_eq("sat_pos_ovf_b", 32'(ovf_b), 32'd1);
        cfg_write(BASE + 16'd2, 8'd1);
        check_eq("arm_clears_ovf", 32'(ovf_b), 32'd0);
        sample_q = {-128, -128, -128, -128, -128, -128, -128, -128};
        send_all();
        exp_a.push_back(word(0, -512)); exp_a.push_back(word(1, -512));
        exp_b.push_back(32'h0000_FF00); exp_b.push_back(32'h0100_FF00);
        drain(2, -1, 0, 1'b0, 1'b0);
        check_eq("sat_neg_ovf_b", 32'(ovf_b), 32'd1);

        // Abort after 3 of 8 samples.
        cfg_write(BASE, 8'd8);
        cfg_write(BASE + 16'd1, 8'd1);
        cfg_write(BASE + 16'd2, 8'd1);
        sample_q = {1, 2, 3};
        send_all();
        check_eq("pre_abort_busy", 32'(busy_a), 32'd1);
        cfg_write(BASE + 16'd2, 8'd2);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_tvalid", 32'(tvalid_a), 32'd0);

        // cfg_rounds=0 acts as one round; idx restarts at 0 after abort.
        cfg_write(BASE, 8'd2);
        cfg_write(BASE + 16'd1, 8'd0);
        cfg_write(BASE + 16'd2, 8'd1);
        sample_q = {3, 4};
        send_all();
        push_both(0, 3); push_both(1, 4);
        drain(2, -1, 0, 1'b0, 1'b0);

        // cfg_spins=0 means NUM_SPINS.
        cfg_write(BASE, 8'd0);
        cfg_write(BASE + 16'd2, 8'd1);
        for (int i = 0; i < NS; i++) begin
            sample_q.push_back(i * 3 - 10);
            push_both(i, i * 3 - 10);
        end
        send_all();
        drain(NS, -1, 0, 1'b0, 1'b0);

        // Oversized cfg_spins clamps to NUM_SPINS.
        cfg_write(BASE, 8'd20);
        cfg_write(BASE + 16'd2, 8'd1);
        for (int i = 0; i < NS; i++) begin
            sample_q.push_back(-i);
            push_both(i, -i);
        end
        send_all();
        drain(NS, -1, 0, 1'b0, 1'b0);

        // w_clk held high with changing data gives one write; wrong addresses are ignored.
        gpio_in = {8'h00, 8'd3, BASE};
        step();
        gpio_in[24] = 1'b1;
        step();
        step();
        gpio_in[23:16] = 8'd5;
        step(); step(); step();
        gpio_in[24] = 1'b0;
        step(); step();
        cfg_write(BASE + 16'd3, 8'd6);
        cfg_write(16'h0000, 8'd6);
        cfg_write(BASE + 16'd2, 8'd1);
        sample_q = {7, 8, 9};
        send_all();
        push_both(0, 7); push_both(1, 8); push_both(2, 9);
        drain(3, -1, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-DRAIN, then a clean run with reset config.
        cfg_write(BASE + 16'd2, 8'd1);
        sample_q = {1, 2, 3};
        tready = 1'b0;
        send_all();
        step();
        check_eq("pre_rst_tvalid", 32'(tvalid_a), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_tvalid", 32'(tvalid_a), 32'd0);
        check_eq("async_rst_busy", 32'(busy_a), 32'd0);
        check_eq("async_rst_tdata", tdata_a, 32'd0);
        check_eq("async_rst_tlast", 32'(tlast_a), 32'd0);
        step();
        rst    = 1'b0;
        tready = 1'b1;
        step();
        cfg_write(BASE + 16'd2, 8'd1);
        for (int i = 0; i < NS; i++) begin
            sample_q.push_back(i + 40);
            push_both(i, i + 40);
        end
        send_all();
        drain(NS, -1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
